// File: rtl/lc3_uart_console.sv
// LC-3 memory-mapped console: KBSR/KBDR/DSR/DDR registers bridging the CPU bus
// to a byte-level UART pair, with an RX byte FIFO and a transmit handshake FSM.
module lc3_uart_console #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] ADDR_KBSR  = 16'hFE00,
  parameter logic [15:0] ADDR_KBDR  = 16'hFE02,
  parameter logic [15:0] ADDR_DSR   = 16'hFE04,
  parameter logic [15:0] ADDR_DDR   = 16'hFE06
) (
  input  logic        i_Clock,
  input  logic        i_Rst_n,
  input  logic [15:0] i_Addr,
  input  logic        i_Rd_En,
  input  logic        i_Wr_En,
  input  logic [15:0] i_Wr_Data,
  output logic [15:0] o_Rd_Data,
  output logic        o_Sel,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic        o_Tx_DV,
  output logic [7:0]  o_Tx_Byte,
  input  logic        i_Tx_Done,
  output logic        o_Int
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_LAUNCH = 2'd1,
    TX_BUSY   = 2'd2
  } tx_state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          kb_ie_q, kb_ie_d, ovr_q, ovr_d, dsr_ie_q, dsr_ie_d;
  logic [15:0]   rd_data_q, rd_data_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          tx_dv_q, tx_dv_d, int_q, int_d;
  tx_state_e     tx_state_q, tx_state_d;

  logic sel_kbsr_s, sel_kbdr_s, sel_dsr_s, sel_ddr_s;
  logic empty_s, full_s, pop_s, push_s, ovr_set_s, tx_idle_s;
  logic unused_s;

  assign sel_kbsr_s = (i_Addr == ADDR_KBSR);
  assign sel_kbdr_s = (i_Addr == ADDR_KBDR);
  assign sel_dsr_s  = (i_Addr == ADDR_DSR);
  assign sel_ddr_s  = (i_Addr == ADDR_DDR);
  assign o_Sel      = sel_kbsr_s | sel_kbdr_s | sel_dsr_s | sel_ddr_s;

  assign empty_s   = (cnt_q == {CW{1'b0}});
  assign full_s    = (cnt_q == FULL_CNT);
  assign pop_s     = i_Rd_En & sel_kbdr_s & ~empty_s;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_s    = i_Rx_DV & (~full_s | pop_s);
  assign ovr_set_s = i_Rx_DV & full_s & ~pop_s;
  assign tx_idle_s = (tx_state_q == TX_IDLE);
  assign unused_s  = ^{i_Wr_Data[15], i_Wr_Data[12:8]};

  // FIFO pointer/count and keyboard status next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    kb_ie_d  = kb_ie_q;
    ovr_d    = ovr_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1'b1);
      2'b01:   cnt_d = cnt_q - CW'(1'b1);
      default: cnt_d = cnt_q;
    endcase
    if (i_Wr_En && sel_kbsr_s) begin
      kb_ie_d = i_Wr_Data[14];
      ovr_d   = ovr_q & ~i_Wr_Data[13];
    end else begin
      kb_ie_d = kb_ie_q;
    end
    // A new overrun event wins over a same-cycle clear.
    if (ovr_set_s) begin
      ovr_d = 1'b1;
    end else begin
      ovr_d = ovr_d;
    end
  end

  // Transmit FSM, display status and interrupt next-state
  always_comb begin
    tx_state_d = tx_state_q;
    tx_byte_d  = tx_byte_q;
    dsr_ie_d   = dsr_ie_q;
    tx_dv_d    = (tx_state_q == TX_LAUNCH);
    case (tx_state_q)
      TX_IDLE: begin
        if (i_Wr_En && sel_ddr_s) begin
          tx_byte_d  = i_Wr_Data[7:0];
          tx_state_d = TX_LAUNCH;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_LAUNCH: tx_state_d = TX_BUSY;
      TX_BUSY: begin
        if (i_Tx_Done) begin
          tx_state_d = TX_IDLE;
        end else begin
          tx_state_d = TX_BUSY;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (i_Wr_En && sel_dsr_s) begin
      dsr_ie_d = i_Wr_Data[14];
    end else begin
      dsr_ie_d = dsr_ie_q;
    end
    int_d = ((cnt_d != {CW{1'b0}}) & kb_ie_d) | ((tx_state_d == TX_IDLE) & dsr_ie_d);
  end

  // Bus read data mux; the value holds until the next matching read
  always_comb begin
    rd_data_d = rd_data_q;
    if (i_Rd_En && o_Sel) begin
      case (1'b1)
        sel_kbsr_s: rd_data_d = {~empty_s, kb_ie_q, ovr_q, 13'h0000};
        sel_kbdr_s: rd_data_d = empty_s ? 16'h0000 : {8'h00, mem_q[rd_ptr_q]};
        sel_dsr_s:  rd_data_d = {tx_idle_s, dsr_ie_q, 14'h0000};
        sel_ddr_s:  rd_data_d = {8'h00, tx_byte_q};
        default:    rd_data_d = rd_data_q;
      endcase
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // State registers
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      cnt_q      <= {CW{1'b0}};
      kb_ie_q    <= 1'b0;
      ovr_q      <= 1'b0;
      dsr_ie_q   <= 1'b0;
      rd_data_q  <= 16'h0000;
      tx_byte_q  <= 8'h00;
      tx_dv_q    <= 1'b0;
      int_q      <= 1'b0;
      tx_state_q <= TX_IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      kb_ie_q    <= kb_ie_d;
      ovr_q      <= ovr_d;
      dsr_ie_q   <= dsr_ie_d;
      rd_data_q  <= rd_data_d;
      tx_byte_q  <= tx_byte_d;
      tx_dv_q    <= tx_dv_d;
      int_q      <= int_d;
      tx_state_q <= tx_state_d;
    end
  end

  // RX FIFO storage
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= i_Rx_Byte;
    end
  end

  assign o_Rd_Data = rd_data_q;
  assign o_Tx_DV   = tx_dv_q;
  assign o_Tx_Byte = tx_byte_q;
  assign o_Int     = int_q;

endmodule

// File: tb/tb_lc3_uart_console.sv
// Self-checking bench for lc3_uart_console: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based reference model.
module tb_lc3_uart_console;

  localparam int DEPTH = 4;
  localparam logic [15:0] A_KBSR = 16'hFE00;
  localparam logic [15:0] A_KBDR = 16'hFE02;
  localparam logic [15:0] A_DSR  = 16'hFE04;
  localparam logic [15:0] A_DDR  = 16'hFE06;
  localparam logic [15:0] A_NONE = 16'h3000;

  logic        clk, rst_n;
  logic [15:0] addr, wr_data;
  logic        rd_en, wr_en, rx_dv, tx_done;
  logic [7:0]  rx_byte;
  logic [15:0] rd_data;
  logic        sel, tx_dv, int_o;
  logic [7:0]  tx_byte;

  int checks = 0;
  int errors = 0;

  lc3_uart_console #(.FIFO_DEPTH(DEPTH)) dut (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Addr(addr), .i_Rd_En(rd_en),
    .i_Wr_En(wr_en), .i_Wr_Data(wr_data), .o_Rd_Data(rd_data), .o_Sel(sel),
    .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte), .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte),
    .i_Tx_Done(tx_done), .o_Int(int_o)
  );

  always #5 clk = ~clk;

  // Reference model: console state as a byte queue plus a few flags.
  logic [7:0]  mq[$];
  bit          m_kb_ie, m_ovr, m_dsr_ie, m_busy;
  int          m_since;
  logic [7:0]  m_tx_byte;
  logic [15:0] m_rd;
  bit          m_dv, m_int;

  task automatic model_reset();
    mq.delete();
    m_kb_ie = 1'b0; m_ovr = 1'b0; m_dsr_ie = 1'b0; m_busy = 1'b0;
    m_since = -1; m_tx_byte = 8'h00; m_rd = 16'h0000; m_dv = 1'b0; m_int = 1'b0;
  endtask

  function automatic bit is_dev(input logic [15:0] a);
    return (a == A_KBSR) || (a == A_KBDR) || (a == A_DSR) || (a == A_DDR);
  endfunction

  task automatic model_step(input logic [15:0] a, input bit rd, input bit wr,
                            input logic [15:0] wd, input bit rx, input logic [7:0] rb,
                            input bit dn);
    bit pre_busy;
    int pre_since;
    bit popped;
    pre_busy = m_busy;
    pre_since = m_since;
    popped = 1'b0;
    if (rd && is_dev(a)) begin
      if (a == A_KBSR) m_rd = {mq.size() != 0, m_kb_ie, m_ovr, 13'h0000};
      else if (a == A_KBDR) m_rd = (mq.size() != 0) ? {8'h00, mq[0]} : 16'h0000;
      else if (a == A_DSR) m_rd = {!m_busy, m_dsr_ie, 14'h0000};
      else m_rd = {8'h00, m_tx_byte};
    end
    if (rd && a == A_KBDR && mq.size() != 0) begin
      void'(mq.pop_front());
      popped = 1'b1;
    end
    if (wr && a == A_KBSR) begin
      m_kb_ie = wd[14];
      if (wd[13]) m_ovr = 1'b0;
    end
    if (wr && a == A_DSR) m_dsr_ie = wd[14];
    if (rx) begin
      if (mq.size() < DEPTH) mq.push_back(rb);
      else m_ovr = 1'b1;
    end
    if (dn && pre_busy && pre_since >= 2) begin
      m_busy = 1'b0;
      m_since = -1;
    end else if (pre_busy && m_since < 3) begin
      m_since = m_since + 1;
    end
    if (wr && a == A_DDR && !pre_busy) begin
      m_tx_byte = wd[7:0];
      m_busy = 1'b1;
      m_since = 1;
    end
    m_dv = (m_since == 2);
    m_int = ((mq.size() != 0) && m_kb_ie) || (!m_busy && m_dsr_ie);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic [15:0] a, input bit rd, input bit wr,
                      input logic [15:0] wd, input bit rx, input logic [7:0] rb,
                      input bit dn);
    addr = a; rd_en = rd; wr_en = wr; wr_data = wd;
    rx_dv = rx; rx_byte = rb; tx_done = dn;
    #1;
    chk("sel", {15'h0000, sel}, {15'h0000, is_dev(a)});
    model_step(a, rd, wr, wd, rx, rb, dn);
    @(posedge clk);
    #1;
    chk("rd_data", rd_data, m_rd);
    chk("tx_dv", {15'h0000, tx_dv}, {15'h0000, m_dv});
    chk("tx_byte", {8'h00, tx_byte}, {8'h00, m_tx_byte});
    chk("int", {15'h0000, int_o}, {15'h0000, m_int});
  endtask

  task automatic idle();
    step(A_NONE, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
  endtask

  typedef struct {
    logic [15:0] a;
    bit          rd, wr;
    logic [15:0] wd;
    bit          rx;
    logic [7:0]  rb;
    bit          dn;
    logic [15:0] e_rd;
    bit          e_int, e_dv;
    logic [7:0]  e_txb;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [15:0] a, input bit rd, input bit wr, input logic [15:0] wd,
                     input bit rx, input logic [7:0] rb, input bit dn,
                     input logic [15:0] e_rd, input bit e_int, input bit e_dv,
                     input logic [7:0] e_txb);
    vec_t v;
    v.a = a; v.rd = rd; v.wr = wr; v.wd = wd; v.rx = rx; v.rb = rb; v.dn = dn;
    v.e_rd = e_rd; v.e_int = e_int; v.e_dv = e_dv; v.e_txb = e_txb;
    tbl.push_back(v);
  endtask

  initial begin
    logic [15:0] ra;
    int r;
    clk = 1'b0; rst_n = 1'b0;
    addr = A_NONE; rd_en = 1'b0; wr_en = 1'b0; wr_data = 16'h0000;
    rx_dv = 1'b0; rx_byte = 8'h00; tx_done = 1'b0;
    model_reset();

    // addr rd wr wdata rx rbyte done | rd_data int dv txbyte
    add(A_KBSR, 1, 0, 16'h0000, 0, 8'h00, 0, 16'h0000, 0, 0, 8'h00);
    add(A_DSR,  1, 0, 16'h0000, 0, 8'h00, 0, 16'h8000, 0, 0, 8'h00);
    add(A_NONE, 0, 0, 16'h0000, 1, 8'h3F, 0, 16'h8000, 0, 0, 8'h00);
    add(A_KBSR, 1, 0, 16'h0000, 0, 8'h00, 0, 16'h8000, 0, 0, 8'h00);
    add(A_KBDR, 1, 0, 16'h0000, 0, 8'h00, 0, 16'h003F, 0, 0, 8'h00);
    add(A_KBSR, 1, 0, 16'h0000, 0, 8'h00, 0, 16'h0000, 0, 0, 8'h00);
    add(A_DDR,  0, 1, 16'h00AB, 0, 8'h00, 0, 16'h0000, 0, 0, 8'hAB);
    add(A_NONE, 0, 0, 16'h0000, 0, 8'h00, 0, 16'h0000, 0, 1, 8'hAB);
    add(A_DSR,  1, 0, 16'h0000, 0, 8'h00, 0, 16'h0000, 0, 0, 8'hAB);
    add(A_DDR,  0, 1, 16'h0055, 0, 8'h00, 0, 16'h0000, 0, 0, 8'hAB);
    add(A_NONE, 0, 0, 16'h0000, 0, 8'h00, 1, 16'h0000, 0, 0, 8'hAB);
    add(A_DSR,  1, 0, 16'h0000, 0, 8'h00, 0, 16'h8000, 0, 0, 8'hAB);
    add(A_DDR,  1, 0, 16'h0000, 0, 8'h00, 0, 16'h00AB, 0, 0, 8'hAB);
    for (int i = 1; i <= 5; i++)
      add(A_NONE, 0, 0, 16'h0000, 1, 8'(i), 0, 16'h00AB, 0, 0, 8'hAB);
    add(A_KBSR, 1, 0, 16'h0000, 0, 8'h00, 0, 16'hA000, 0, 0, 8'hAB);
    for (int i = 1; i <= 4; i++)
      add(A_KBDR, 1, 0, 16'h0000, 0, 8'h00, 0, 16'(i), 0, 0, 8'hAB);
    add(A_KBDR, 1, 0, 16'h0000, 0, 8'h00, 0, 16'h0000, 0, 0, 8'hAB);
    add(A_KBSR, 0, 1, 16'h2000, 0, 8'h00, 0, 16'h0000, 0, 0, 8'hAB);
    add(A_KBSR, 1, 0, 16'h0000, 0, 8'h00, 0, 16'h0000, 0, 0, 8'hAB);
    add(A_NONE, 0, 0, 16'h0000, 1, 8'hAA, 0, 16'h0000, 0, 0, 8'hAB);
    add(A_NONE, 0, 0, 16'h0000, 1, 8'hBB, 0, 16'h0000, 0, 0, 8'hAB);
    add(A_NONE, 0, 0, 16'h0000, 1, 8'hCC, 0, 16'h0000, 0, 0, 8'hAB);
    add(A_NONE, 0, 0, 16'h0000, 1, 8'hDD, 0, 16'h0000, 0, 0, 8'hAB);
    add(A_KBDR, 1, 0, 16'h0000, 1, 8'h77, 0, 16'h00AA, 0, 0, 8'hAB);
    add(A_KBSR, 1, 0, 16'h0000, 0, 8'h00, 0, 16'h8000, 0, 0, 8'hAB);
    add(A_KBDR, 1, 0, 16'h0000, 0, 8'h00, 0, 16'h00BB, 0, 0, 8'hAB);
    add(A_KBDR, 1, 0, 16'h0000, 0, 8'h00, 0, 16'h00CC, 0, 0, 8'hAB);
    add(A_KBDR, 1, 0, 16'h0000, 0, 8'h00, 0, 16'h00DD, 0, 0, 8'hAB);
    add(A_KBDR, 1, 0, 16'h0000, 0, 8'h00, 0, 16'h0077, 0, 0, 8'hAB);
    add(A_KBSR, 0, 1, 16'h4000, 0, 8'h00, 0, 16'h0077, 0, 0, 8'hAB);
    add(A_NONE, 0, 0, 16'h0000, 1, 8'h10, 0, 16'h0077, 1, 0, 8'hAB);
    add(A_KBDR, 1, 0, 16'h0000, 0, 8'h00, 0, 16'h0010, 0, 0, 8'hAB);

    #12;
    chk("rst_rd", rd_data, 16'h0000);
    chk("rst_dv", {15'h0000, tx_dv}, 16'h0000);
    chk("rst_txb", {8'h00, tx_byte}, 16'h0000);
    chk("rst_int", {15'h0000, int_o}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].a, tbl[i].rd, tbl[i].wr, tbl[i].wd, tbl[i].rx, tbl[i].rb, tbl[i].dn);
      chk($sformatf("tbl%0d_rd", i), rd_data, tbl[i].e_rd);
      chk($sformatf("tbl%0d_int", i), {15'h0000, int_o}, {15'h0000, tbl[i].e_int});
      chk($sformatf("tbl%0d_dv", i), {15'h0000, tx_dv}, {15'h0000, tbl[i].e_dv});
      chk($sformatf("tbl%0d_txb", i), {8'h00, tx_byte}, {8'h00, tbl[i].e_txb});
    end

    // Push and pop in the same cycle on an empty FIFO.
    step(A_KBSR, 1'b0, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b0);
    step(A_KBDR, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h5A, 1'b0);
    chk("empty_pushpop_rd", rd_data, 16'h0000);
    step(A_KBSR, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
    chk("empty_pushpop_kbsr", rd_data, 16'h8000);
    step(A_KBDR, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
    chk("empty_pushpop_kbdr", rd_data, 16'h005A);

    // Tx_Done during the launch cycle is ignored; DSR interrupt follows ready.
    step(A_DSR, 1'b0, 1'b1, 16'h4000, 1'b0, 8'h00, 1'b0);
    chk("dsr_ie_int", {15'h0000, int_o}, 16'h0001);
    step(A_DDR, 1'b0, 1'b1, 16'h00C3, 1'b0, 8'h00, 1'b0);
    chk("busy_int", {15'h0000, int_o}, 16'h0000);
    step(A_NONE, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);
    chk("launch_dv", {15'h0000, tx_dv}, 16'h0001);
    step(A_DSR, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
    chk("early_done_ignored", rd_data, 16'h4000);

    // Reset while busy abandons the transmit.
    idle();
    rst_n = 1'b0;
    #1;
    chk("midrst_rd", rd_data, 16'h0000);
    chk("midrst_int", {15'h0000, int_o}, 16'h0000);
    chk("midrst_txb", {8'h00, tx_byte}, 16'h0000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(A_DSR, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
    chk("post_rst_dsr", rd_data, 16'h8000);

    for (int n = 0; n < 2000; n++) begin
      r = $urandom_range(0, 4);
      case (r)
        0: ra = A_KBSR;
        1: ra = A_KBDR;
        2: ra = A_DSR;
        3: ra = A_DDR;
        default: ra = 16'($urandom);
      endcase
      r = $urandom_range(0, 9);
      step(ra, r < 4, r >= 4 && r < 6, 16'($urandom), $urandom_range(0, 2) == 0,
           8'($urandom), $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3_uart_console.md
Name: lc3_uart_console

Overview:
- Memory-mapped LC-3 console device: implements the KBSR/KBDR/DSR/DDR registers on the CPU's memory bus.
- Acts as the byte-level partner of the serial engines:
  - consumes received bytes from uart_rx (o_Rx_DV/o_Rx_Byte) into a small FIFO;
  - drives uart_tx (i_Tx_DV/i_Tx_Byte) and waits on o_Tx_Done.
- Sits between the LC-3 memory controller and the UART pair; raises an interrupt request for keyboard/display ready.

Parameters:
- FIFO_DEPTH, 4, RX byte FIFO entries; power of two, minimum 2.
- ADDR_KBSR, 16'hFE00, keyboard status register address.
- ADDR_KBDR, 16'hFE02, keyboard data register address.
- ADDR_DSR, 16'hFE04, display status register address.
- ADDR_DDR, 16'hFE06, display data register address.

Ports:
- i_Clock  in  1  system clock, all logic on rising edge.
- i_Rst_n  in  1  reset, asynchronous assert, active-low.
- i_Addr  in  16  bus address.
- i_Rd_En  in  1  bus read strobe, one cycle.
- i_Wr_En  in  1  bus write strobe, one cycle.
- i_Wr_Data  in  16  bus write data.
- o_Rd_Data  out  16  read data, registered.
- o_Sel  out  1  combinational: i_Addr matches any of the four addresses.
- i_Rx_DV  in  1  one-cycle pulse, i_Rx_Byte valid.
- i_Rx_Byte  in  8  received byte.
- o_Tx_DV  out  1  one-cycle pulse to start a transmit.
- o_Tx_Byte  out  8  byte to transmit, held stable from o_Tx_DV until i_Tx_Done.
- i_Tx_Done  in  1  one-cycle pulse, transmit complete.
- o_Int  out  1  interrupt request, registered.

Behaviour:
- Reset values (async, i_Rst_n=0): o_Rd_Data=0, o_Tx_DV=0, o_Tx_Byte=0, o_Int=0; FIFO empty; KBSR IE=0, overrun=0; DSR IE=0; TX FSM in IDLE.
- Bus access:
  - Accesses take effect only when the address matches; i_Rd_En and i_Wr_En are never asserted together.
  - Read data appears on o_Rd_Data the cycle after i_Rd_En and holds until the next read.
- KBSR read: [15]=FIFO not empty, [14]=IE, [13]=overrun, others 0.
- KBSR write: [14] loads IE; [13]=1 clears overrun (write-1-to-clear); other bits ignored.
- KBDR read:
  - Returns {8'h00, FIFO head} and pops the FIFO.
  - If the FIFO is empty it returns 16'h0000 and does not pop.
- KBDR write: ignored.
- RX push:
  - i_Rx_DV with FIFO not full writes i_Rx_Byte at the tail.
  - With FIFO full the byte is dropped and overrun is set (sticky).
- Simultaneous RX push and KBDR pop:
  - Both happen in the same cycle; the count is unchanged.
  - When the FIFO is full, the push succeeds (the pop frees the slot) and overrun does not set.
  - When the FIFO is empty, the pushed byte is not returned that cycle (read returns 0) and the count becomes 1.
- FIFO pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.
- DSR read: [15]=TX FSM in IDLE, [14]=IE, others 0.
- DSR write: [14] loads IE.
- DDR read: returns {8'h00, o_Tx_Byte}.
- TX FSM:
  - IDLE: DDR write latches i_Wr_Data[7:0] into o_Tx_Byte -> LAUNCH.
  - LAUNCH: o_Tx_DV=1 for exactly this one cycle -> BUSY.
  - BUSY: wait for i_Tx_Done -> IDLE.
  - i_Tx_Done in any other state is ignored.
- DDR write while not IDLE: ignored entirely; o_Tx_Byte is unchanged and no extra o_Tx_DV is issued.
- DSR ready drops the cycle after the accepted DDR write and returns the cycle after i_Tx_Done.
- o_Int is registered: (KB ready & KB IE) | (DSR ready & DSR IE), updated every cycle.
- Reset mid-operation: all state clears immediately. FIFO contents are lost, and an in-flight transmit is abandoned (no i_Tx_Done is expected after reset).

Test Plan:
- Reset, read KBSR then DSR -> 16'h0000 then 16'h8000; o_Int=0, o_Tx_DV never pulses.
- Pulse i_Rx_DV with 8'h3F -> KBSR reads 16'h8000; KBDR reads 16'h003F; KBSR then reads 16'h0000.
- Write DDR=16'h00AB -> o_Tx_DV pulses 2 cycles after the write with o_Tx_Byte=8'hAB; DSR reads 16'h0000. A second DDR write of 16'h0055 while BUSY is ignored; after i_Tx_Done, DSR reads 16'h8000 and DDR reads 16'h00AB.
- Push 5 bytes 8'h01..8'h05 with FIFO_DEPTH=4 -> KBSR reads 16'hA000. KBDR reads 01,02,03,04, then 0000. Write KBSR=16'h2000 -> KBSR reads 16'h0000.
- Fill the FIFO, then pulse i_Rx_DV (8'h77) in the same cycle as a KBDR read -> read returns the oldest byte, overrun stays 0, and 8'h77 is later read last.
- Write KBSR=16'h4000, push 8'h10 -> o_Int=1 the cycle after the push; read KBDR -> o_Int returns to 0 within 2 cycles. Assert i_Rst_n=0 while BUSY -> DSR reads 16'h8000 after release.
